// File: rtl/arb_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arb_pkt_pkg
// Purpose : Shared types and helpers for the packet-aware WRR arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package arb_pkt_pkg;

  // Helpers work on a fixed maximum requester count; callers zero-extend.
  localparam int MAX_REQ = 16;
  localparam int IDX_W   = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First set request at or after ptr, wrapping at width-1 back to 0.
  function automatic rr_pick_t rr_first_one(input logic [MAX_REQ-1:0] req,
                                            input logic [IDX_W-1:0]   ptr,
                                            input int                 width);
    rr_pick_t pick;
    int       j;
    pick = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < width) begin
        j = int'(ptr) + i;
        if (j >= width) j = j - width;
        if (!pick.found && req[j[IDX_W-1:0]]) begin
          pick.found = 1'b1;
          pick.idx   = j[IDX_W-1:0];
        end
      end
    end
    return pick;
  endfunction

  // One-hot vector from an index.
  function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_pkt_wrr_reg_slice.sv
`default_nettype none
// ============================================================================
// Module  : reg_slice_2e
// Purpose : Two-entry valid/ready skid buffer. Upstream ready depends only on
//           the registered fill level, never on downstream ready.
// Revision: 1.0 - initial release
// ============================================================================
module reg_slice_2e #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_data,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_data
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q;
  logic          push;
  logic          pop;

  assign in_rdy   = (count_q != 2'd2);
  assign out_vld  = (count_q != 2'd0);
  assign out_data = mem_q[rd_ptr_q];
  assign push     = in_vld && in_rdy;
  assign pop      = out_vld && out_rdy;

  // Storage, pointers and fill level; reset drops any buffered beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/arb_pkt_wrr.sv
`default_nettype none
// ============================================================================
// Module  : arb_pkt_wrr
// Purpose : Packet-aware weighted round-robin arbiter. The grant is held until
//           a packet boundary; the owner may send up to its weight in packets
//           before the grant rotates. Optional 2-entry output skid slice.
// Revision: 1.0 - initial release
// ============================================================================
module arb_pkt_wrr
  import arb_pkt_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PLD_WIDTH = 32,
  parameter int WGT_WIDTH = 4,
  parameter int OUT_REG   = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [WIDTH-1:0]                v_vld_s,
  output logic [WIDTH-1:0]                v_rdy_s,
  input  logic [PLD_WIDTH-1:0]            v_pld_s [WIDTH],
  input  logic [WIDTH-1:0]                v_last_s,
  input  logic [WIDTH-1:0][WGT_WIDTH-1:0] v_weight,
  output logic                            vld_m,
  input  logic                            rdy_m,
  output logic [PLD_WIDTH-1:0]            pld_m,
  output logic                            last_m,
  output logic [$clog2(WIDTH)-1:0]        gnt_id_m,
  output logic                            busy
);

  localparam int GID_W    = $clog2(WIDTH);
  localparam int SLICE_DW = GID_W + 1 + PLD_WIDTH;

  arb_state_e           state_q, state_d;
  logic [GID_W-1:0]     ptr_q, ptr_d;
  logic [GID_W-1:0]     owner_q, owner_d;
  logic [WGT_WIDTH-1:0] credit_q, credit_d;
  logic                 sop_q, sop_d;

  rr_pick_t             pick;
  logic [GID_W-1:0]     pick_idx;
  logic [WGT_WIDTH-1:0] pick_wgt;
  logic [MAX_REQ-1:0]   owner_oh_full;
  logic [WIDTH-1:0]     owner_sel;
  logic [GID_W-1:0]     owner_inc;
  logic                 lock;
  logic                 owner_vld;
  logic                 owner_last;
  logic                 others_vld;
  logic                 accept;
  logic [PLD_WIDTH-1:0] mux_pld;
  logic                 slice_in_vld;
  logic                 slice_in_rdy;
  logic                 slice_in_last;
  logic [PLD_WIDTH-1:0] slice_in_pld;
  logic                 unused_bits;

  assign pick          = rr_first_one(MAX_REQ'(v_vld_s), IDX_W'(ptr_q), WIDTH);
  assign pick_idx      = pick.idx[GID_W-1:0];
  assign pick_wgt      = v_weight[pick_idx];
  assign owner_oh_full = idx_to_onehot(IDX_W'(owner_q));
  assign owner_sel     = owner_oh_full[WIDTH-1:0];
  assign owner_inc     = (owner_q == GID_W'(WIDTH - 1)) ? '0 : owner_q + GID_W'(1);
  assign unused_bits   = ^{pick.idx, owner_oh_full};

  assign lock          = (state_q == LOCK);
  assign busy          = lock;
  assign owner_vld     = |(v_vld_s & owner_sel);
  assign owner_last    = |(v_last_s & owner_sel);
  assign others_vld    = |(v_vld_s & ~owner_sel);

  assign slice_in_vld  = lock && owner_vld;
  assign slice_in_last = lock && owner_last;
  assign slice_in_pld  = lock ? mux_pld : '0;
  assign accept        = slice_in_vld && slice_in_rdy;
  assign v_rdy_s       = lock ? (owner_sel & {WIDTH{slice_in_rdy}}) : '0;

  // One-hot AND-OR payload mux; only the owner's payload can pass.
  always_comb begin
    mux_pld = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (owner_sel[i]) mux_pld = mux_pld | v_pld_s[i];
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      credit_q <= '0;
      sop_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      credit_q <= credit_d;
      sop_q    <= sop_d;
    end
  end

  // Next-state: grant in IDLE, packet-counted session and early release in LOCK.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    credit_d = credit_q;
    sop_d    = sop_q;
    case (state_q)
      IDLE: begin
        if (pick.found) begin
          owner_d  = pick_idx;
          // A zero weight still buys one packet so nobody can be starved.
          credit_d = (pick_wgt == '0) ? WGT_WIDTH'(1) : pick_wgt;
          sop_d    = 1'b1;
          state_d  = LOCK;
        end
      end
      LOCK: begin
        if (accept) begin
          sop_d = owner_last;
          if (owner_last) begin
            credit_d = credit_q - WGT_WIDTH'(1);
            if (credit_q == WGT_WIDTH'(1)) begin
              ptr_d   = owner_inc;
              state_d = IDLE;
            end
          end
        end else if (sop_q && !owner_vld && others_vld) begin
          // Owner idle at a packet boundary while others wait: give it up.
          ptr_d   = owner_inc;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [SLICE_DW-1:0] slice_out;

      reg_slice_2e #(
        .DW (SLICE_DW)
      ) u_slice (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (slice_in_vld),
        .in_rdy   (slice_in_rdy),
        .in_data  ({owner_q, slice_in_last, slice_in_pld}),
        .out_vld  (vld_m),
        .out_rdy  (rdy_m),
        .out_data (slice_out)
      );

      assign {gnt_id_m, last_m, pld_m} = slice_out;
    end else begin : g_out_comb
      assign slice_in_rdy = rdy_m;
      assign vld_m        = slice_in_vld;
      assign pld_m        = slice_in_pld;
      assign last_m       = slice_in_last;
      assign gnt_id_m     = owner_q;
    end
  endgenerate

endmodule
`default_nettype wire
